seq_magnitude_compare: RTL and testbench
========================================

Name: seq_magnitude_compare

Overview:
- Multi-cycle, iterative magnitude comparator for 16-bit operands.
- Scans operands MSB-first, BITS_PER_CYCLE bits per cycle, and exits early at the first differing group.
- Returns registered gt/lt/eq flags with a start/done handshake, signed or unsigned per request.
- Serves as the reusable compare engine behind set-condition and branch-resolve logic when the single-cycle compare path is off the critical path.

Parameters:
- WIDTH, 16: operand width in bits.
- BITS_PER_CYCLE, 4: bits examined per scan cycle. Must divide WIDTH; G = WIDTH/BITS_PER_CYCLE groups.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request strobe; accepted only in IDLE.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- InA  input  WIDTH  operand A; sampled with start.
- InB  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while state is SCAN.
- done  output  1  one-cycle pulse when results become valid.
- gt  output  1  A > B (registered).
- lt  output  1  A < B (registered).
- eq  output  1  A == B (registered).

Behaviour:
- Reset: when rst_n is low at a rising edge, state=IDLE, busy=0, done=0, gt=0, lt=0, eq=0, group index=0. Operand registers are don't-care.
- Reset mid-SCAN aborts the operation. No done pulse is issued for the aborted request.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 at an edge latches InA, InB and is_signed, clears index to 0, and moves to SCAN.
  - gt/lt/eq keep their previous values until overwritten.
- Signed handling: at latch, when is_signed=1, bit WIDTH-1 of both operands is inverted. All later comparison is unsigned on the latched values.
- SCAN (busy=1): each cycle compares group `index` combinationally. Group 0 is bits [WIDTH-1 -: BITS_PER_CYCLE], i.e. MSB first.
  - Group differs: at the next edge, register gt/lt from that group's unsigned compare, set eq=0, and go to DONE.
  - Groups equal and index == G-1: at the next edge, register eq=1, gt=0, lt=0, and go to DONE.
  - Otherwise: index increments and the state stays in SCAN.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE unconditionally.
- Flag invariant: exactly one of gt/lt/eq is high after the first completion. All three are 0 only between reset and the first completion.
- Latency: start accepted at edge E0 (IDLE to SCAN).
  - If the first differing group is k (0-based), the DONE state is entered at edge E0+k+1.
  - If the operands are equal, DONE is entered at edge E0+G.
  - Minimum 1 cycle, maximum G cycles from acceptance to done.
- Throughput: a new start is accepted in the IDLE cycle after DONE, i.e. at the earliest at edge E0+k+3.
- start while busy=1 or while in DONE is ignored. It is not queued and latched operands do not change.
- Operand inputs may change freely after the accept edge; results depend only on the latched values.
- gt/lt/eq stay stable from done until the next completion. They are not cleared by a new start.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with start=1 -> busy=0, done=0, gt=lt=eq=0. Release, idle 3 cycles -> no done pulse.
- Early exit, unsigned: InA=16'hF000, InB=16'h0FFF, is_signed=0 -> done one cycle after accept (group 0 differs), gt=1, lt=0, eq=0.
- Signed, sign bit differs: InA=16'h8000 (-32768), InB=16'h0001, is_signed=1 -> lt=1 after 1 cycle. Same operands with is_signed=0 -> gt=1.
- Full scan:
  - InA=InB=16'hA5A5 -> done exactly 4 cycles after accept, eq=1, busy high for 4 cycles.
  - InA=16'h1235, InB=16'h1234 -> done at cycle 4, gt=1.
  - Signed InA=16'hFFFE (-2), InB=16'hFFFF (-1) -> lt=1 at cycle 4.
- start while busy: accept A=16'h0010, B=16'h0020. One cycle later pulse start with A=16'hFFFF, B=16'h0000 -> single done with lt=1 from the first request. No second done pulse follows.
- Reset mid-SCAN: accept A=B=16'h1111, drive rst_n=0 at cycle 2 -> no done pulse, flags return to 0. After release, a new request A=16'h0002, B=16'h0001 completes normally with gt=1.

Source files
------------

// File: rtl/seq_magnitude_compare_if.sv
// -----------------------------------------------------------------------------
// seq_magnitude_compare_if
//
// Purpose: bundles the request and result signals of the iterative magnitude
// comparator so the requester and the engine connect through one port each.
//
// Handshake: the requester raises start together with InA, InB and is_signed.
// The engine takes the request only while it is idle (busy=0, done=0). A start
// seen at any other time is dropped, not queued. Results gt/lt/eq are valid in
// the cycle where done is high and hold their value until the next completion.
// The requester may change the operands freely once the request is taken.
//
// Signals:
//   start      request strobe (requester -> engine)
//   is_signed  1 = two's-complement compare, 0 = unsigned
//   InA, InB   operands, sampled with start
//   busy       engine is scanning
//   done       one-cycle pulse, results valid
//   gt/lt/eq   registered result flags
// -----------------------------------------------------------------------------
interface seq_magnitude_compare_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] InA;
  logic [WIDTH-1:0] InB;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  // Requester side.
  modport master (
    output start, is_signed, InA, InB,
    input  busy, done, gt, lt, eq
  );

  // Compare engine side.
  modport slave (
    input  start, is_signed, InA, InB,
    output busy, done, gt, lt, eq
  );
endinterface

// File: rtl/seq_magnitude_compare.sv
// -----------------------------------------------------------------------------
// seq_magnitude_compare
//
// Purpose: multi-cycle magnitude comparator. It scans the latched operands
// MSB-first, BITS_PER_CYCLE bits per cycle, and stops at the first group that
// differs. Signed compares are reduced to unsigned ones by flipping the sign
// bit of both operands when they are latched.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        seq_magnitude_compare_if.slave (start/is_signed/InA/InB in,
//              busy/done/gt/lt/eq out)
//   dbg_state  current FSM state (IDLE=0, SCAN=1, DONE=2) for observation
//
// Timing: a start taken at edge E0 enters DONE at edge E0+k+1 when group k is
// the first to differ, or at E0+G when the operands are equal. DONE lasts one
// cycle, then the FSM returns to IDLE and may take the next start.
// -----------------------------------------------------------------------------
module seq_magnitude_compare #(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  seq_magnitude_compare_if.slave     bus,
  output logic [1:0]                 dbg_state
);

  localparam int G     = WIDTH / BITS_PER_CYCLE;
  localparam int IDX_W = (G > 1) ? $clog2(G) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(G - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [WIDTH-1:0]  a_q, a_nxt;
  logic [WIDTH-1:0]  b_q, b_nxt;
  logic              gt_q, gt_nxt;
  logic              lt_q, lt_nxt;
  logic              eq_q, eq_nxt;

  // The operand registers are shifted left after every equal group, so the
  // group under test always sits in the top BITS_PER_CYCLE bits. This avoids
  // a variable part-select indexed by idx.
  logic [BITS_PER_CYCLE-1:0] grp_a;
  logic [BITS_PER_CYCLE-1:0] grp_b;

  assign grp_a = a_q[WIDTH-1 -: BITS_PER_CYCLE];
  assign grp_b = b_q[WIDTH-1 -: BITS_PER_CYCLE];

  // State and datapath registers. The operands are not reset because they
  // are always reloaded before they are used.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      gt_q  <= gt_nxt;
      lt_q  <= lt_nxt;
      eq_q  <= eq_nxt;
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_nxt;
    b_q <= b_nxt;
  end

  // Next-state and datapath logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    a_nxt     = a_q;
    b_nxt     = b_q;
    gt_nxt    = gt_q;
    lt_nxt    = lt_q;
    eq_nxt    = eq_q;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          // Flipping the sign bit maps two's-complement order onto
          // unsigned order, so the scan itself never needs to know the mode.
          a_nxt     = bus.is_signed ? (bus.InA ^ MSB_MASK) : bus.InA;
          b_nxt     = bus.is_signed ? (bus.InB ^ MSB_MASK) : bus.InB;
          idx_nxt   = '0;
          state_nxt = S_SCAN;
        end
      end

      S_SCAN: begin
        if (grp_a != grp_b) begin
          // The first differing group decides the whole compare.
          gt_nxt    = (grp_a > grp_b);
          lt_nxt    = (grp_a < grp_b);
          eq_nxt    = 1'b0;
          state_nxt = S_DONE;
        end else if (idx == LAST_IDX) begin
          gt_nxt    = 1'b0;
          lt_nxt    = 1'b0;
          eq_nxt    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          idx_nxt = idx + IDX_W'(1);
          a_nxt   = a_q << BITS_PER_CYCLE;
          b_nxt   = b_q << BITS_PER_CYCLE;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy  = (state == S_SCAN);
  assign bus.done  = (state == S_DONE);
  assign bus.gt    = gt_q;
  assign bus.lt    = lt_q;
  assign bus.eq    = eq_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// -----------------------------------------------------------------------------
// tb_seq_magnitude_compare
//
// Directed bench for seq_magnitude_compare. The driver pushes the expected
// flags and latency of every request into exp_q; a monitor pops and compares
// on every done pulse. Expected values are hand-computed from the operands.
// Expected entry layout: {latency[7:0], gt, lt, eq}.
// -----------------------------------------------------------------------------
module tb_seq_magnitude_compare;

  localparam int WIDTH = 16;
  localparam int W     = 11;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  seq_magnitude_compare_if #(.WIDTH(WIDTH)) bus ();

  seq_magnitude_compare #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / cycle counter
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every done pulse must match the oldest outstanding expectation.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W-1:0] e;
        int           t0;
        e  = exp_q.pop_front();
        t0 = acc_q.pop_front();
        check("flags_gt_lt_eq", {29'd0, bus.gt, bus.lt, bus.eq}, {29'd0, e[2:0]});
        check("latency", 32'(cyc - t0), {24'd0, e[10:3]});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [2:0] flags, input int lat, input bit expect_result);
    if (expect_result) exp_q.push_back({8'(lat), flags});
    bus.start     = 1'b1;
    bus.InA       = a;
    bus.InB       = b;
    bus.is_signed = s;
    @(negedge clk);
    if (expect_result) acc_q.push_back(cyc);
    bus.start     = 1'b0;
    // Scramble the operand inputs to show results use only latched values.
    bus.InA       = 16'($urandom_range(0, 65535));
    bus.InB       = 16'($urandom_range(0, 65535));
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Flag encodings {gt, lt, eq}
  localparam logic [2:0] F_GT = 3'b100;
  localparam logic [2:0] F_LT = 3'b010;
  localparam logic [2:0] F_EQ = 3'b001;

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int busy_cnt;

    rst_n         = 1'b0;
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.InA       = 16'h1234;
    bus.InB       = 16'h4321;

    // Reset held for two edges with start asserted.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_flags", {29'd0, bus.gt, bus.lt, bus.eq}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    idle(3);
    check("post_rst_flags", {29'd0, bus.gt, bus.lt, bus.eq}, 32'd0);

    // Early exits (group 0 or 1 decides).
    issue(16'hF000, 16'h0FFF, 1'b0, F_GT, 1, 1'b1); drain();
    issue(16'h8000, 16'h0001, 1'b1, F_LT, 1, 1'b1); drain();
    issue(16'h8000, 16'h0001, 1'b0, F_GT, 1, 1'b1); drain();
    issue(16'h0000, 16'hFFFF, 1'b0, F_LT, 1, 1'b1); drain();
    issue(16'h7FFF, 16'h8000, 1'b1, F_GT, 1, 1'b1); drain();
    issue(16'h1200, 16'h1300, 1'b0, F_LT, 2, 1'b1); drain();

    // Full scan, equal operands; busy must be high exactly 4 cycles.
    issue(16'hA5A5, 16'hA5A5, 1'b0, F_EQ, 4, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) break;
      busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles_eq", 32'(busy_cnt), 32'd4);
    drain();

    issue(16'h1235, 16'h1234, 1'b0, F_GT, 4, 1'b1); drain();
    issue(16'hFFFE, 16'hFFFF, 1'b1, F_LT, 4, 1'b1); drain();

    // start while busy is dropped: only the first request completes.
    issue(16'h0010, 16'h0020, 1'b0, F_LT, 3, 1'b1);
    issue(16'hFFFF, 16'h0000, 1'b0, 3'b000, 0, 1'b0);
    drain();
    idle(6);
    check("ignored_start_flags", {29'd0, bus.gt, bus.lt, bus.eq}, {29'd0, F_LT});

    // Reset mid-SCAN aborts without a done pulse and clears the flags.
    issue(16'h1111, 16'h1111, 1'b0, 3'b000, 0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_flags", {29'd0, bus.gt, bus.lt, bus.eq}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    idle(6);
    issue(16'h0002, 16'h0001, 1'b0, F_GT, 4, 1'b1); drain();

    idle(3);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
